// File: rtl/timer_seq_pkg.sv
// Shared types and helpers for the timer_sequencer block: FSM states, run mode
// and the effective-modulus mapping where a programmed 0 means 2**WIDTH.
package timer_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    ONESHOT = 1'b0,
    RELOAD  = 1'b1
  } mode_t;

  function automatic int unsigned eff_mod(input int unsigned m, input int unsigned w);
    return (m == 0) ? (32'd1 << w) : m;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable divider for timer_sequencer: tick asserts once every div+1 enabled
// clocks. Phase is held while en is low and restarts from zero on clr.
module tick_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [PRE_W-1:0] div,
  output logic             tick
);

  logic [PRE_W-1:0] cnt;

  // >= rather than == so a live shrink of div below the phase cannot cause a long wrap.
  assign tick = en && (cnt >= div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// Modulo-N event counter controller with start/pause/stop sequencing, a
// registered one-cycle terminal-count pulse and a valid/ready config port.
// Optional prescaler on the count tick is enabled by defining PRESCALER_EN.
module timer_sequencer
  import timer_seq_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_MOD = 10,
  parameter int PRE_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_mod,
  input  logic             cfg_reload,
  input  logic             start,
  input  logic             stop,
`ifdef PRESCALER_EN
  input  logic [PRE_W-1:0] pre_div,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           state;
  mode_t            reload_q;
  logic [WIDTH-1:0] mod_q;
  logic [WIDTH-1:0] last;
  logic             cfg_acc;
  logic             start_go;
  logic             tick;

  assign cfg_ready = (state == IDLE) || (state == DONE);
  assign busy      = (state == RUN) || (state == HOLD);
  assign cfg_acc   = cfg_valid && cfg_ready;
  // Stop outranks start whenever both are requested together.
  assign start_go  = cfg_ready && start && !stop;
  assign last      = WIDTH'(eff_mod(32'(mod_q), WIDTH) - 32'd1);

`ifdef PRESCALER_EN
  tick_prescaler #(
    .PRE_W(PRE_W)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (start_go),
    .en  ((state == RUN) && !stop),
    .div (pre_div),
    .tick(tick)
  );
`else
  // Without a prescaler every clock is a count tick.
  assign tick = (PRE_W > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      tc       <= 1'b0;
      done     <= 1'b0;
      mod_q    <= WIDTH'(DEFAULT_MOD);
      reload_q <= RELOAD;
    end else begin
      tc <= 1'b0;
      if (cfg_acc) begin
        mod_q    <= cfg_mod;
        reload_q <= mode_t'(cfg_reload);
        done     <= 1'b0;
      end
      case (state)
        IDLE, DONE: begin
          if (start_go) begin
            state <= RUN;
            count <= '0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= HOLD;
          end else if (tick) begin
            if (count == last) begin
              count <= '0;
              tc    <= 1'b1;
              if (reload_q == ONESHOT) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              count <= count + WIDTH'(1);
            end
          end
        end
        HOLD: begin
          if (stop) begin
            state <= IDLE;
            count <= '0;
          end else if (start) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer: reset, decade counting, one-shot, pause and
// resume, config blocking while busy, modulus 0 and 1, async reset, prescaler.
module tb_timer_sequencer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [W-1:0] cfg_mod = '0;
  logic         cfg_reload = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;
  logic         done;
`ifdef PRESCALER_EN
  logic [7:0]   pre_div = 8'd0;
`endif

  int total = 0;
  int bad = 0;
  int tcs = 0;

  timer_sequencer #(
    .WIDTH(W),
    .DEFAULT_MOD(10),
    .PRE_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mod   (cfg_mod),
    .cfg_reload(cfg_reload),
    .start     (start),
    .stop      (stop),
`ifdef PRESCALER_EN
    .pre_div   (pre_div),
`endif
    .count     (count),
    .tc        (tc),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_tc", tc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cfg_ready, 1);
    step();
    rst = 1'b0;

    // Decade counting with default modulus
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_start_count", count, 0);
    chk("t1_start_tc", tc, 0);
    chk("t1_busy", busy, 1);
    chk("t1_ready", cfg_ready, 0);
    for (int i = 1; i <= 9; i++) begin
      step();
      chk("t1_count", count, i);
      chk("t1_tc_low", tc, 0);
    end
    step();
    chk("t1_wrap_count", count, 0);
    chk("t1_wrap_tc", tc, 1);
    step();
    chk("t1_after_count", count, 1);
    chk("t1_after_tc", tc, 0);

    // Stop twice back to IDLE, then one-shot mod 5
    stop = 1'b1;
    step();
    chk("t2_hold_count", count, 1);
    chk("t2_hold_busy", busy, 1);
    step();
    stop = 1'b0;
    chk("t2_idle_count", count, 0);
    chk("t2_idle_busy", busy, 0);
    chk("t2_idle_ready", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_mod = 4'd5; cfg_reload = 1'b0;
    step();
    cfg_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t2_start_count", count, 0);
    chk("t2_start_busy", busy, 1);
    tcs = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t2_count", count, i);
      tcs += int'(tc);
    end
    chk("t2_no_early_tc", tcs, 0);
    step();
    chk("t2_end_count", count, 0);
    chk("t2_end_tc", tc, 1);
    chk("t2_end_done", done, 1);
    chk("t2_end_busy", busy, 0);
    chk("t2_end_ready", cfg_ready, 1);
    step();
    chk("t2_post_tc", tc, 0);
    chk("t2_post_done", done, 1);
    chk("t2_post_count", count, 0);

    // Config with start on same edge, pause at 3, resume, stop twice
    cfg_valid = 1'b1; cfg_mod = 4'd10; cfg_reload = 1'b1; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    chk("t3_done_clr", done, 0);
    chk("t3_count0", count, 0);
    step(); step(); step();
    chk("t3_count3", count, 3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t3_hold_count", count, 3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_frozen", count, 3);
      chk("t3_frozen_tc", tc, 0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_resume_count", count, 3);
    chk("t3_resume_busy", busy, 1);
    step();
    chk("t3_count4", count, 4);
    stop = 1'b1;
    step();
    chk("t3_hold4", count, 4);
    step();
    stop = 1'b0;
    chk("t3_idle_count", count, 0);
    chk("t3_idle_busy", busy, 0);

    // Config offered while running is refused
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_valid = 1'b1; cfg_mod = 4'd3; cfg_reload = 1'b0;
    #1;
    chk("t4_ready_low", cfg_ready, 0);
    for (int i = 1; i <= 9; i++) begin
      step();
      chk("t4_count", count, i);
    end
    step();
    chk("t4_wrap_count", count, 0);
    chk("t4_wrap_tc", tc, 1);
    chk("t4_still_busy", busy, 1);
    cfg_valid = 1'b0;
    stop = 1'b1;
    step(); step();
    stop = 1'b0;

    // Modulus 0 means 16
    cfg_valid = 1'b1; cfg_mod = 4'd0; cfg_reload = 1'b1; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      chk("t4_m0_count", count, i);
      chk("t4_m0_tc", tc, 0);
    end
    step();
    chk("t4_m0_wrap", count, 0);
    chk("t4_m0_tc_wrap", tc, 1);
    stop = 1'b1;
    step(); step();
    stop = 1'b0;

    // Modulus 1: tc on every tick
    cfg_valid = 1'b1; cfg_mod = 4'd1; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    chk("m1_start_tc", tc, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("m1_count", count, 0);
      chk("m1_tc", tc, 1);
    end
    stop = 1'b1;
    step(); step();
    stop = 1'b0;

    // Async reset mid-run restores default modulus
    cfg_valid = 1'b1; cfg_mod = 4'd12; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("t5_count7", count, 7);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_count", count, 0);
    chk("t5_rst_tc", tc, 0);
    chk("t5_rst_busy", busy, 0);
    #1 rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("t5_count9", count, 9);
    step();
    chk("t5_wrap10", count, 0);
    chk("t5_wrap10_tc", tc, 1);
    step();
    chk("t5_reload_busy", busy, 1);

`ifdef PRESCALER_EN
    // Prescaled counting and phase freeze in HOLD
    stop = 1'b1;
    step(); step();
    stop = 1'b0;
    pre_div = 8'd2;
    cfg_valid = 1'b1; cfg_mod = 4'd4; cfg_reload = 1'b1; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      chk("t6_count", count, (n / 3) % 4);
      chk("t6_tc", tc, (n == 12) ? 1 : 0);
    end
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_hold", count, 0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t6_phase_kept", count, 0);
    step();
    chk("t6_phase_step", count, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
